nios2_oci_dct_packer: RTL and testbench
=======================================

Name: nios2_oci_dct_packer

Overview:
- Direct-compressed-trace (DCT) packer that sits directly upstream of the OCI trace test-bench monitor stage.
- Accepts 2-bit trace atoms from the CPU trace interface and packs up to 15 of them into a 30-bit buffer, exposed live as dct_buffer/dct_count.
- Hands full or flushed words to the trace sink through a valid/ready output register.
- Generates test_ending/test_has_ended for an orderly end-of-trace drain.

Parameters:
- ATOM_W, 2, bits per trace atom
- SLOTS, 15, atoms per packed word
- BUF_W, 30, packed word width; must equal ATOM_W*SLOTS
- CNT_W, 4, width of atom counts; must hold SLOTS

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- atom_valid  in  1  atom present this cycle
- atom  in  2  trace atom: 00 nop, 01 taken, 10 not-taken, 11 exception
- flush  in  1  push partial buffer out as a word
- end_request  in  1  pulse; begin end-of-trace drain
- word_ready  in  1  sink accepts word_data this cycle
- word_valid  out  1  output register holds a word
- word_data  out  30  packed word; atom k at bits [2k+1:2k]
- word_count  out  4  atoms in word_data, 1..15
- dct_buffer  out  30  live packing buffer
- dct_count  out  4  atoms currently in dct_buffer, 0..15
- overflow  out  1  sticky: an atom was dropped
- test_ending  out  1  drain in progress
- test_has_ended  out  1  drain complete

Behaviour:
- Reset (synchronous, highest priority, allowed mid-operation): all outputs go to 0 and the FSM goes to RUN. The held word is discarded and overflow is cleared.
- FSM states:
  - RUN: normal packing. On end_request, go to DRAIN.
  - DRAIN: atoms are ignored; flush is forced every cycle. Go to ENDED when dct_count==0 and word_valid==0.
  - ENDED: terminal until reset.
- Flags: test_ending=1 exactly in DRAIN. test_has_ended=1 exactly in ENDED.
- Packing (RUN, atom_valid=1): the atom is written at slot dct_count and dct_count increments. The update is visible on dct_buffer/dct_count 1 cycle later.
- Nop atoms are packed like any other atom; there is no filtering.
- Unused slots above dct_count read as 0.
- Emit condition: the atom that fills slot 14, or flush with (dct_count + incoming atom) > 0.
- Emit is allowed when the output register is free (word_valid=0, or word_ready=1 in this same cycle). On emit:
  - the next cycle shows word_data = buffer including the incoming atom, word_count = its atom count, word_valid=1;
  - the buffer clears to 0 and dct_count to 0.
- 15th atom with the output register blocked: the buffer stays full (dct_count=15) and the word emits on the first cycle the register frees.
- Atom arriving while dct_count=15 and the register is blocked: the atom is dropped and overflow sets (sticky).
- Flush with an empty buffer and no atom: no-op, no word.
- Flush with the register blocked: the flush is held pending and the emit happens when the register frees. Atoms arriving meanwhile are appended until full.
- Simultaneous atom + flush: the atom is included in the flushed word.
- Output handshake: word_valid holds and word_data/word_count stay stable until word_ready=1. Transfer occurs on a cycle with word_valid & word_ready. A new word may load in the same cycle.
- end_request while in DRAIN or ENDED: ignored.
- Latency: 15th atom to word_valid = 1 cycle.

Optional Feature:
- Macro: DCT_TIMESTAMP_EN.
- Defined:
  - adds a 16-bit free-running cycle counter, reset to 0, wrapping 0xFFFF->0;
  - adds output port word_timestamp[15:0], loaded with the counter value on the emit cycle and held with word_data.
- Undefined: no counter and no port; behaviour is otherwise identical.

Decomposition:
- Package nios2_oci_dct_pkg holds:
  - ATOM_W, SLOTS, BUF_W, CNT_W;
  - atom encodings ATOM_NOP/ATOM_TAKEN/ATOM_NOT_TAKEN/ATOM_EXC;
  - FSM state typedef dct_state_t {RUN, DRAIN, ENDED}.
- One sub-module, nios2_oci_dct_outreg: the valid/ready holding register for word_data/word_count (and word_timestamp under the macro). It exports a "free" signal to the packer.

Test Plan:
- Reset, then 15 atoms 01 back-to-back with word_ready=1 -> word_valid=1 the cycle after the 15th atom; word_data=0x15555555, word_count=15, then dct_count=0.
- Atoms 10,11,01, then flush -> word_data=0x0000001E (atom0 at [1:0]), word_count=3, dct_buffer=0.
- word_ready=0, 31 atoms 01 -> word 1 held, dct_count=15, atom 31 dropped, overflow=1; raising word_ready -> second word emits, overflow stays 1.
- Atom 11 coinciding with flush at dct_count=2 -> word_count=3, bits [5:4]=11.
- 4 atoms, end_request -> test_ending=1, word_count=4 word emitted, later atoms ignored; after acceptance test_has_ended=1, test_ending=0.
- reset asserted mid-DRAIN with word_valid=1 -> next cycle all outputs 0, FSM in RUN; with DCT_TIMESTAMP_EN, the word emitted at cycle 20 after reset carries word_timestamp=20.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared widths, atom encodings and FSM state type for the DCT trace packer.
package nios2_oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = ATOM_W * SLOTS;
    localparam int CNT_W  = 4;

    localparam logic [ATOM_W-1:0] ATOM_NOP       = 2'b00;
    localparam logic [ATOM_W-1:0] ATOM_TAKEN     = 2'b01;
    localparam logic [ATOM_W-1:0] ATOM_NOT_TAKEN = 2'b10;
    localparam logic [ATOM_W-1:0] ATOM_EXC       = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_t;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// Valid/ready holding register for packed trace words; word_timestamp exists
// only when DCT_TIMESTAMP_EN is defined.
module nios2_oci_dct_outreg
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
`ifdef DCT_TIMESTAMP_EN
    input  logic [15:0]      load_timestamp,
    output logic [15:0]      word_timestamp,
`endif
    input  logic             word_ready,
    output logic             word_valid,
    output logic [BUF_W-1:0] word_data,
    output logic [CNT_W-1:0] word_count,
    output logic             free
);

    // The register can take a new word when empty or when it is being drained now.
    assign free = !word_valid || word_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_valid     <= 1'b0;
            word_data      <= '0;
            word_count     <= '0;
`ifdef DCT_TIMESTAMP_EN
            word_timestamp <= '0;
`endif
        end else if (load) begin
            word_valid     <= 1'b1;
            word_data      <= load_data;
            word_count     <= load_count;
`ifdef DCT_TIMESTAMP_EN
            word_timestamp <= load_timestamp;
`endif
        end else if (word_ready) begin
            word_valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// DCT packer: packs 2-bit trace atoms into 30-bit words and drains them at
// end of trace. Optional DCT_TIMESTAMP_EN adds a cycle timestamp per word.
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom,
    input  logic              flush,
    input  logic              end_request,
    input  logic              word_ready,
    output logic              word_valid,
    output logic [BUF_W-1:0]  word_data,
    output logic [CNT_W-1:0]  word_count,
`ifdef DCT_TIMESTAMP_EN
    output logic [15:0]       word_timestamp,
`endif
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow,
    output logic              test_ending,
    output logic              test_has_ended
);

    dct_state_t       state_q;
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flush_pend_q;
    logic             overflow_q;
    logic             out_free;

    logic             in_run, flush_req, atom_in, buf_full, take_atom;
    logic             emit, carry, drop;
    logic [BUF_W-1:0] merged_buf;
    logic [CNT_W-1:0] merged_cnt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_run     = (state_q == RUN);
        flush_req  = in_run ? (flush || flush_pend_q) : (state_q == DRAIN);
        atom_in    = in_run && atom_valid;
        buf_full   = (cnt_q == CNT_W'(SLOTS));
        take_atom  = atom_in && !buf_full;
        merged_buf = buf_q;
        merged_cnt = cnt_q;
        if (take_atom) begin
            merged_buf = buf_q | (BUF_W'(atom) << (ATOM_W * int'(cnt_q)));
            merged_cnt = cnt_q + CNT_W'(1);
        end
        emit  = ((merged_cnt == CNT_W'(SLOTS)) || (flush_req && merged_cnt != '0)) && out_free;
        // An atom meeting a full buffer starts the next word if the full one leaves now.
        carry = atom_in && buf_full && out_free;
        drop  = atom_in && buf_full && !out_free;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (emit) begin
                buf_q        <= carry ? BUF_W'(atom) : '0;
                cnt_q        <= carry ? CNT_W'(1) : '0;
                flush_pend_q <= carry && flush_req;
            end else begin
                buf_q        <= merged_buf;
                cnt_q        <= merged_cnt;
                flush_pend_q <= in_run && flush_req && (merged_cnt != '0);
            end
            if (drop)
                overflow_q <= 1'b1;
            case (state_q)
                RUN:     if (end_request) state_q <= DRAIN;
                DRAIN:   if (cnt_q == '0 && !word_valid) state_q <= ENDED;
                default: state_q <= ENDED;
            endcase
        end
    end

`ifdef DCT_TIMESTAMP_EN
    logic [15:0] cycle_q;

    always_ff @(posedge clk) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 16'd1;
    end
`endif

    nios2_oci_dct_outreg u_outreg (
        .clk            (clk),
        .reset          (reset),
        .load           (emit),
        .load_data      (merged_buf),
        .load_count     (merged_cnt),
`ifdef DCT_TIMESTAMP_EN
        .load_timestamp (cycle_q),
        .word_timestamp (word_timestamp),
`endif
        .word_ready     (word_ready),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_count     (word_count),
        .free           (out_free)
    );

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign overflow       = overflow_q;
    assign test_ending    = (state_q == DRAIN);
    assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer: directed steps plus random
// traffic checked against a queue-based reference model.
module tb_nios2_oci_dct_packer;
    import nios2_oci_dct_pkg::*;

    logic        clk = 1'b0;
    logic        reset, atom_valid, flush, end_request, word_ready;
    logic [1:0]  atom;
    logic        word_valid, overflow, test_ending, test_has_ended;
    logic [29:0] word_data, dct_buffer;
    logic [3:0]  word_count, dct_count;
`ifdef DCT_TIMESTAMP_EN
    logic [15:0] word_timestamp;
`endif

    nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush          (flush),
        .end_request    (end_request),
        .word_ready     (word_ready),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_count     (word_count),
`ifdef DCT_TIMESTAMP_EN
        .word_timestamp (word_timestamp),
`endif
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: the packing buffer is a queue of atoms, state 0/1/2 = run/drain/ended.
    int          m_q[$];
    bit          m_pend, m_ov, m_wv;
    int          m_state;
    logic [29:0] m_wdata;
    int          m_wcnt;
    int          m_cyc, m_wts;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pack_q();
        logic [29:0] v = '0;
        foreach (m_q[k]) v = v | (30'(m_q[k]) << (2 * k));
        return v;
    endfunction

    function automatic void model_step(input bit rst, input bit av, input logic [1:0] a,
                                       input bit fl_in, input bit er, input bit rdy);
        bit run, fl, free, old_wv;
        int old_cnt, spill;
        if (rst) begin
            m_q.delete();
            m_pend = 0; m_ov = 0; m_wv = 0; m_state = 0;
            m_wdata = '0; m_wcnt = 0; m_cyc = 0; m_wts = 0;
            return;
        end
        old_cnt = m_q.size();
        old_wv  = m_wv;
        run     = (m_state == 0);
        fl      = run ? (fl_in || m_pend) : (m_state == 1);
        free    = !m_wv || rdy;
        if (m_wv && rdy) m_wv = 0;
        spill = -1;
        if (run && av) begin
            if (m_q.size() < SLOTS) m_q.push_back(int'(a));
            else spill = int'(a);
        end
        if ((m_q.size() == SLOTS || (fl && m_q.size() > 0)) && free) begin
            m_wdata = pack_q();
            m_wcnt  = m_q.size();
            m_wv    = 1;
            m_wts   = m_cyc;
            m_q.delete();
            if (spill >= 0) m_q.push_back(spill);
            m_pend = run && fl && (m_q.size() > 0);
        end else begin
            if (spill >= 0) m_ov = 1;
            m_pend = run && fl && (m_q.size() > 0);
        end
        if (m_state == 0 && er) m_state = 1;
        else if (m_state == 1 && old_cnt == 0 && !old_wv) m_state = 2;
        m_cyc = (m_cyc + 1) % 65536;
    endfunction

    task automatic compare_all();
        check("word_valid", 32'(word_valid), 32'(m_wv));
        if (m_wv) begin
            check("word_data", 32'(word_data), 32'(m_wdata));
            check("word_count", 32'(word_count), 32'(m_wcnt));
`ifdef DCT_TIMESTAMP_EN
            check("word_timestamp", 32'(word_timestamp), 32'(m_wts));
`endif
        end
        check("dct_buffer", 32'(dct_buffer), 32'(pack_q()));
        check("dct_count", 32'(dct_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("test_ending", 32'(test_ending), 32'(m_state == 1));
        check("test_has_ended", 32'(test_has_ended), 32'(m_state == 2));
    endtask

    task automatic tick(input bit rst, input bit av, input logic [1:0] a,
                        input bit fl, input bit er, input bit rdy);
        reset = rst; atom_valid = av; atom = a; flush = fl; end_request = er; word_ready = rdy;
        @(posedge clk);
        model_step(rst, av, a, fl, er, rdy);
        #1;
        compare_all();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0;
        end_request = 1'b0; word_ready = 1'b0;
        tick(1, 0, 2'b00, 0, 0, 0);
        tick(1, 0, 2'b00, 0, 0, 0);
        check("reset_valid", 32'(word_valid), 32'd0);
        check("reset_count", 32'(dct_count), 32'd0);
        check("reset_flags", 32'({overflow, test_ending, test_has_ended}), 32'd0);

        // 15 taken atoms back-to-back
        for (int i = 0; i < 15; i++) tick(0, 1, 2'b01, 0, 0, 1);
        check("full_valid", 32'(word_valid), 32'd1);
        check("full_data", 32'(word_data), 32'h15555555);
        check("full_count", 32'(word_count), 32'd15);
        check("full_dct_count", 32'(dct_count), 32'd0);
        tick(0, 0, 2'b00, 0, 0, 1);

        // partial flush
        tick(0, 1, 2'b10, 0, 0, 1);
        tick(0, 1, 2'b11, 0, 0, 1);
        tick(0, 1, 2'b01, 0, 0, 1);
        tick(0, 0, 2'b00, 1, 0, 1);
        check("flush_data", 32'(word_data), 32'h0000001E);
        check("flush_count", 32'(word_count), 32'd3);
        check("flush_buffer", 32'(dct_buffer), 32'd0);
        tick(0, 0, 2'b00, 1, 0, 1);
        check("flush_empty_noop", 32'(word_valid), 32'd0);

        // backpressure and overflow
        for (int i = 0; i < 30; i++) tick(0, 1, 2'b01, 0, 0, 0);
        check("bp_no_overflow_yet", 32'(overflow), 32'd0);
        tick(0, 1, 2'b01, 0, 0, 0);
        check("bp_held_valid", 32'(word_valid), 32'd1);
        check("bp_dct_count", 32'(dct_count), 32'd15);
        check("bp_overflow", 32'(overflow), 32'd1);
        tick(0, 0, 2'b00, 0, 0, 1);
        check("bp_second_valid", 32'(word_valid), 32'd1);
        check("bp_second_count", 32'(word_count), 32'd15);
        check("bp_dct_cleared", 32'(dct_count), 32'd0);
        check("bp_overflow_sticky", 32'(overflow), 32'd1);
        tick(0, 0, 2'b00, 0, 0, 1);

        // atom coinciding with flush
        tick(0, 1, 2'b01, 0, 0, 1);
        tick(0, 1, 2'b01, 0, 0, 1);
        tick(0, 1, 2'b11, 1, 0, 1);
        check("atom_flush_count", 32'(word_count), 32'd3);
        check("atom_flush_slot2", 32'(word_data[5:4]), 32'd3);
        tick(0, 0, 2'b00, 0, 0, 1);

        // end-of-trace drain
        for (int i = 0; i < 4; i++) tick(0, 1, 2'b10, 0, 0, 1);
        tick(0, 0, 2'b00, 0, 1, 0);
        check("drain_ending", 32'(test_ending), 32'd1);
        tick(0, 0, 2'b00, 0, 0, 0);
        check("drain_word_valid", 32'(word_valid), 32'd1);
        check("drain_word_count", 32'(word_count), 32'd4);
        tick(0, 1, 2'b01, 0, 0, 0);
        check("drain_atom_ignored", 32'(dct_count), 32'd0);
        begin
            int budget = 10;
            while (!test_has_ended && budget > 0) begin
                tick(0, 0, 2'b00, 0, 0, 1);
                budget--;
            end
        end
        check("ended_flag", 32'(test_has_ended), 32'd1);
        check("ended_not_ending", 32'(test_ending), 32'd0);

        // reset in the middle of a drain with a word held
        tick(1, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 2'b01, 0, 0, 0);
        tick(0, 0, 2'b00, 0, 1, 0);
        tick(0, 0, 2'b00, 0, 0, 0);
        check("mid_drain_valid", 32'(word_valid), 32'd1);
        tick(1, 0, 2'b00, 0, 0, 0);
        check("mid_reset_outputs", 32'({word_valid, overflow, test_ending, test_has_ended}), 32'd0);
        check("mid_reset_data", 32'(word_data), 32'd0);
        check("mid_reset_buffer", 32'(dct_buffer), 32'd0);
        tick(0, 1, 2'b11, 0, 0, 1);
        check("after_reset_run", 32'(dct_count), 32'd1);
        for (int i = 0; i < 19; i++) tick(0, 0, 2'b00, 0, 0, 1);
        tick(0, 0, 2'b00, 1, 0, 1);
        check("ts_word_count", 32'(word_count), 32'd1);
`ifdef DCT_TIMESTAMP_EN
        check("ts_value", 32'(word_timestamp), 32'd20);
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 150) == 0, ($urandom % 3) != 0, 2'($urandom),
                 ($urandom % 8) == 0, ($urandom % 70) == 0, ($urandom % 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
